// File: rtl/dmem_dump_pkg.sv
// Shared types for the data-memory debug dump reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_dump_pkg;

    // Dump controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Byte stride between consecutive words
    localparam int WORD_BYTES = 4;

    // One streamed beat: byte address, memory word, final-beat flag
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

endpackage

// File: rtl/dmem_dump_fifo2.sv
// Two-entry synchronous FIFO of dump beats with first-word-fall-through head.
// Latency: a pushed beat is visible on dout the cycle after the push.
// Backpressure: none internally; the producer must never push into a full FIFO (checked by assertion).
module dmem_dump_fifo2
    import dmem_dump_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  beat_t      din,
    output beat_t      dout,
    output logic       vld,
    output logic [1:0] occ
);

    beat_t      mem_q [2];
    beat_t      mem_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] occ_q, occ_d;
    logic       do_push, do_pop;

    // Flush wins over a same-cycle push or pop
    assign do_push = push & ~flush;
    assign do_pop  = pop & (occ_q != 2'd0) & ~flush;

    // Pointer, occupancy and storage update
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            occ_d = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = ~wr_q;
            end
            if (do_pop) begin
                rd_d = ~rd_q;
            end
            occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Register FIFO state
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign dout = mem_q[rd_q];
    assign vld  = (occ_q != 2'd0);
    assign occ  = occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && occ_q == 2'd2));

endmodule

// File: rtl/dmem_dump_reader.sv
// Walks a word-aligned data-RAM region through debug port B and streams the words out.
// Latency: first beat valid 2 cycles after start; then up to 1 beat/cycle.
// Backpressure: dout_ready stalls reads; at most 2 words are outstanding (FIFO + in-flight).
module dmem_dump_reader
    import dmem_dump_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      A2,
    output logic [3:0]       WE2,
    output logic [31:0]      WD2,
    input  logic [31:0]      RD2,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [31:0]      dout_data,
    output logic [31:0]      dout_addr,
    output logic             dout_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      a2_q, a2_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             infl_q, infl_d;
    logic             infl_last_q, infl_last_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    beat_t            fifo_din, fifo_head;
    logic             fifo_vld;
    logic [1:0]       fifo_occ;
    logic             pop, push, flush, issue_room;
    logic [2:0]       level;

    // The read issued last cycle returns on RD2 now; it is captured with its address and last flag.
    assign pop        = fifo_vld & dout_ready;
    assign flush      = abort & ((state_q == RUN) | (state_q == DRAIN));
    assign push       = infl_q & ~flush;
    assign fifo_din   = '{addr: a2_q, data: RD2, last: infl_last_q};
    assign level      = {1'b0, fifo_occ} + {2'b00, infl_q} - {2'b00, pop};
    assign issue_room = (level < 3'd2);

    // Next-state and read-issue decisions; a valid start doubles as the first read issue
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        a2_d        = a2_q;
        rem_d       = rem_q;
        infl_d      = 1'b0;
        infl_last_d = infl_last_q;
        err_d       = err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (base_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d  = 1'b0;
                        busy_d = 1'b1;
                        if (word_count == '0) begin
                            state_d = FIN;
                            done_d  = 1'b1;
                        end else begin
                            a2_d        = base_addr;
                            addr_d      = base_addr + 32'(WORD_BYTES);
                            rem_d       = word_count - CNT_W'(1);
                            infl_d      = 1'b1;
                            infl_last_d = (word_count == CNT_W'(1));
                            state_d     = (word_count == CNT_W'(1)) ? DRAIN : RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if ((rem_q != '0) && issue_room) begin
                    a2_d        = addr_q;
                    addr_d      = addr_q + 32'(WORD_BYTES);
                    rem_d       = rem_q - CNT_W'(1);
                    infl_d      = 1'b1;
                    infl_last_d = (rem_q == CNT_W'(1));
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (pop && fifo_head.last) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            a2_q        <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            a2_q        <= a2_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    dmem_dump_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_din),
        .dout  (fifo_head),
        .vld   (fifo_vld),
        .occ   (fifo_occ)
    );

    // Port B is read-only from this block
    assign A2         = a2_q;
    assign WE2        = 4'b0000;
    assign WD2        = 32'd0;
    assign dout_valid = fifo_vld;
    assign dout_data  = fifo_head.data;
    assign dout_addr  = fifo_head.addr;
    assign dout_last  = fifo_head.last;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Bench for dmem_dump_reader: directed dumps, scoreboard of expected beats, negedge monitor.
// Latency: n/a.
// Backpressure: dout_ready driven per test (held high or toggled).
module tb_dmem_dump_reader;
    import dmem_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [31:0] a2, wd2, rd2, dout_data, dout_addr;
    logic [3:0]  we2;
    logic        dout_valid, dout_last, busy, done, err;
    logic        dout_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_beats = 0;
    int n_done = 0;
    int start_cyc = 0;
    bit zero_mode = 1'b0;
    bit done_chk_pending = 1'b0;
    bit stall_prev = 1'b0;
    logic [31:0] hold_data, hold_addr;
    logic        hold_last;
    beat_t       sb_q[$];
    int          hs_cyc_q[$];
    beat_t       got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM preload word(i) = 0xA000_0000 + i; the A2 flop is the RAM's registered read address
    assign rd2 = 32'hA000_0000 + {2'b00, a2[31:2]};

    dmem_dump_reader #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .A2         (a2),
        .WE2        (we2),
        .WD2        (wd2),
        .RD2        (rd2),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_addr  (dout_addr),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic l);
        beat_t e;
        e.addr = a;
        e.data = d;
        e.last = l;
        sb_q.push_back(e);
    endtask

    // Drive a one-cycle start; optionally queue the expected beats from the RAM preload
    task automatic issue(input logic [31:0] b, input logic [15:0] n, input bit auto_exp);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        start_cyc  = cyc;
        if (auto_exp) begin
            for (int i = 0; i < int'(n); i++) begin
                push_exp(b + 32'(i * 4), exp_word(b + 32'(i * 4)), (i == int'(n) - 1));
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_idle(input bit toggle, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (toggle) dout_ready = ~dout_ready;
            if (!busy && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dump_completes_in_budget", 32'(ok), 32'd1);
        dout_ready = 1'b1;
    endtask

    // Monitor: port-B safety, stall stability, done timing, issue lead, scoreboard compare
    always @(negedge clk) begin
        if (!rst) begin
            chk("we2_zero", 32'(we2), 32'd0);
            chk("wd2_zero", wd2, 32'd0);
            if (stall_prev) begin
                chk("stall_valid_held", 32'(dout_valid), 32'd1);
                chk("stall_data_held", dout_data, hold_data);
                chk("stall_addr_held", dout_addr, hold_addr);
                chk("stall_last_held", 32'(dout_last), 32'(hold_last));
            end
            if (done_chk_pending) begin
                chk("done_after_last_beat", 32'(done), 32'd1);
                done_chk_pending = 1'b0;
            end else if (done && !zero_mode) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end
            if (done) n_done++;
            if (busy && sb_q.size() > 0) begin
                chk("a2_lead_le_2_words", 32'((a2 - sb_q[0].addr) <= 32'd4), 32'd1);
            end
            if (dout_valid && dout_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat_addr", dout_addr, 32'hFFFF_FFFF);
                end else begin
                    got = sb_q.pop_front();
                    chk("beat_addr", dout_addr, got.addr);
                    chk("beat_data", dout_data, got.data);
                    chk("beat_last", 32'(dout_last), 32'(got.last));
                    done_chk_pending = got.last;
                end
                n_beats++;
                hs_cyc_q.push_back(cyc);
            end
            stall_prev = dout_valid && !dout_ready && !abort;
            hold_data  = dout_data;
            hold_addr  = dout_addr;
            hold_last  = dout_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0;
        logic [31:0] a2_save;
        bit hit;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_a2", a2, 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_data", dout_data, 32'd0);
        chk("rst_addr", dout_addr, 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // 1: base 0x100, count 4, ready high
        hs_cyc_q.delete();
        d0 = n_done;
        push_exp(32'h0000_0100, 32'hA000_0040, 1'b0);
        push_exp(32'h0000_0104, 32'hA000_0041, 1'b0);
        push_exp(32'h0000_0108, 32'hA000_0042, 1'b0);
        push_exp(32'h0000_010C, 32'hA000_0043, 1'b1);
        issue(32'h0000_0100, 16'd4, 1'b0);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        run_until_idle(1'b0, 40);
        chk("t1_beat_count", 32'(hs_cyc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_cyc_q.size(); i++) begin
            chk("t1_beat_cycle", 32'(hs_cyc_q[i]), 32'(start_cyc + 2 + i));
        end
        chk("t1_done_count", 32'(n_done - d0), 32'd1);

        // 2: count 8 with ready toggling 1,0,1,0
        b0 = n_beats;
        d0 = n_done;
        issue(32'h0000_0100, 16'd8, 1'b1);
        run_until_idle(1'b1, 80);
        chk("t2_beat_count", 32'(n_beats - b0), 32'd8);
        chk("t2_done_count", 32'(n_done - d0), 32'd1);

        // 3: count 0 -> done next cycle, no beats
        b0 = n_beats;
        zero_mode = 1'b1;
        issue(32'h0000_0100, 16'd0, 1'b0);
        chk("t3_done_pulse", 32'(done), 32'd1);
        chk("t3_busy_pulse", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t3_done_ends", 32'(done), 32'd0);
        chk("t3_busy_ends", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1 zero_mode = 1'b0;
        chk("t3_no_beats", 32'(n_beats - b0), 32'd0);

        // 4: misaligned base rejected, then aligned restart clears err
        b0 = n_beats;
        a2_save = a2;
        issue(32'h0000_0102, 16'd4, 1'b0);
        chk("t4_err_set", 32'(err), 32'd1);
        chk("t4_busy_low", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_a2_unchanged", a2, a2_save);
        chk("t4_no_beats", 32'(n_beats - b0), 32'd0);
        chk("t4_err_sticky", 32'(err), 32'd1);
        issue(32'h0000_0100, 16'd2, 1'b1);
        chk("t4_err_cleared", 32'(err), 32'd0);
        chk("t4_busy_restart", 32'(busy), 32'd1);
        run_until_idle(1'b0, 40);

        // 5: abort after two beats, then held start, then clean restart
        b0 = n_beats;
        d0 = n_done;
        hit = 1'b0;
        issue(32'h0000_0000, 16'd8, 1'b1);
        for (int n = 0; n < 40; n++) begin
            if (n_beats - b0 == 2) begin
                abort = 1'b1;
                dout_ready = 1'b0;
                sb_q.delete();
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t5_reached_two_beats", 32'(hit), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_valid_after_abort", 32'(dout_valid), 32'd0);
        chk("t5_busy_after_abort", 32'(busy), 32'd0);
        dout_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        chk("t5_two_beats_only", 32'(n_beats - b0), 32'd2);
        issue(32'h0000_0000, 16'd3, 1'b1);
        base_addr  = 32'h0000_0200;
        word_count = 16'd5;
        start      = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        run_until_idle(1'b0, 40);
        issue(32'h0000_0040, 16'd2, 1'b1);
        run_until_idle(1'b0, 40);

        // 6: address wrap at the top of the space
        push_exp(32'hFFFF_FFF8, 32'hDFFF_FFFE, 1'b0);
        push_exp(32'hFFFF_FFFC, 32'hDFFF_FFFF, 1'b0);
        push_exp(32'h0000_0000, 32'hA000_0000, 1'b1);
        issue(32'hFFFF_FFF8, 16'd3, 1'b0);
        run_until_idle(1'b0, 40);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
